// File: rtl/string_hw_pkg.sv
// string_hw_pkg: shared opcodes, FSM states and ASCII constants for string_hw.
package string_hw_pkg;
    typedef enum logic [2:0] {
        OP_CMP    = 3'd0,
        OP_UPPER  = 3'd1,
        OP_LOWER  = 3'd2,
        OP_STRLEN = 3'd3
    } op_t;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;
    localparam logic [7:0] CASE_DELTA = 8'h20;
    localparam logic [7:0] LC_LO = 8'h61;
    localparam logic [7:0] LC_HI = 8'h7A;
    localparam logic [7:0] UC_LO = 8'h41;
    localparam logic [7:0] UC_HI = 8'h5A;
endpackage

// File: rtl/string_hw_byte_alu.sv
// string_hw_byte_alu: per-byte case conversion, equality and (with STRING_HW_STRLEN_EN) non-zero flag.
module string_hw_byte_alu
    import string_hw_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] upper,
    output logic [7:0] lower,
`ifdef STRING_HW_STRLEN_EN
    output logic       nz,
`endif
    output logic       eq
);
    assign upper = (a >= LC_LO && a <= LC_HI) ? a - CASE_DELTA : a;
    assign lower = (a >= UC_LO && a <= UC_HI) ? a + CASE_DELTA : a;
    assign eq    = a == b;
`ifdef STRING_HW_STRLEN_EN
    assign nz    = a != 8'h00;
`endif
endmodule

// File: rtl/string_hw.sv
// string_hw: byte-serial string compare/case-convert engine, 4 bytes LSB first.
// Optional strlen on index 3 when STRING_HW_STRLEN_EN is defined.
module string_hw
    import string_hw_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic [2:0]  index,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  length,
    output logic        done,
    output logic [31:0] result
);
    state_t      state;
    logic [2:0]  cnt, len_q, op_q;
    logic [31:0] a_q, b_q, work, res_n, res_ext;
    logic        eq_acc, eq_b, in_win;
    logic [7:0]  a_b, b_b, up_b, lo_b, nb;
    logic [4:0]  sel;

    assign sel    = {cnt[1:0], 3'b000};
    assign a_b    = a_q[sel +: 8];
    assign b_b    = b_q[sel +: 8];
    assign in_win = cnt < len_q;
    assign done   = state == S_DONE;
    assign nb     = (op_q == OP_UPPER) ? up_b : (op_q == OP_LOWER) ? lo_b : a_b;

`ifdef STRING_HW_STRLEN_EN
    logic [2:0] nz_cnt;
    logic       nz_b;
    assign res_ext = (op_q == OP_STRLEN) ? {29'b0, nz_cnt} : 32'b0;
`else
    assign res_ext = 32'b0;
`endif

    assign res_n = (op_q == OP_CMP) ? {31'b0, eq_acc}
                 : (op_q == OP_UPPER || op_q == OP_LOWER) ? work : res_ext;

    string_hw_byte_alu u_alu (
        .a     (a_b),
        .b     (b_b),
        .upper (up_b),
        .lower (lo_b),
`ifdef STRING_HW_STRLEN_EN
        .nz    (nz_b),
`endif
        .eq    (eq_b)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= 3'd0;
            len_q  <= 3'd0;
            op_q   <= 3'd0;
            a_q    <= 32'b0;
            b_q    <= 32'b0;
            work   <= 32'b0;
            eq_acc <= 1'b0;
            result <= 32'b0;
`ifdef STRING_HW_STRLEN_EN
            nz_cnt <= 3'd0;
`endif
        end else begin
            case (state)
                S_IDLE: if (go) begin
                    a_q    <= A;
                    b_q    <= B;
                    work   <= A;
                    op_q   <= index;
                    len_q  <= (length == 3'd0 || length > 3'd4) ? 3'd4 : length;
                    cnt    <= 3'd0;
                    eq_acc <= 1'b1;
`ifdef STRING_HW_STRLEN_EN
                    nz_cnt <= 3'd0;
`endif
                    state  <= S_RUN;
                end
                // cnt 0..3 walks bytes LSB first; cnt==4 publishes the result
                S_RUN: if (cnt == 3'd4) begin
                    result <= res_n;
                    state  <= S_DONE;
                end else begin
                    cnt <= cnt + 3'd1;
                    if (in_win) begin
                        work[sel +: 8] <= nb;
                        eq_acc         <= eq_acc & eq_b;
`ifdef STRING_HW_STRLEN_EN
                        nz_cnt         <= nz_cnt + {2'b0, nz_b};
`endif
                    end
                end
                S_DONE: if (!go) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_string_hw.sv
// tb_string_hw: directed self-checking bench for string_hw.
module tb_string_hw;
    logic        clk = 1'b0, reset = 1'b0, go = 1'b0;
    logic [2:0]  index = 3'd0, length = 3'd0;
    logic [31:0] A = 32'b0, B = 32'b0, result;
    logic        done;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    string_hw dut (
        .clk    (clk),
        .reset  (reset),
        .go     (go),
        .index  (index),
        .A      (A),
        .B      (B),
        .length (length),
        .done   (done),
        .result (result)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!done && k < 20);
        chk({tag, "_latency"}, 32'(k), 32'd5);
    endtask

    task automatic run(input string tag, input logic [2:0] idx, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] len, input logic [31:0] exp);
        @(negedge clk);
        index = idx; A = a; B = b; length = len; go = 1'b1;
        @(posedge clk); #1;
        A = 32'hDEADBEEF; B = ~b; index = idx ^ 3'd3; length = 3'd1;
        wait_done(tag);
        chk(tag, result, exp);
        @(posedge clk); #1;
        chk({tag, "_hold_done"}, {31'b0, done}, 32'd1);
        @(negedge clk);
        go = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_done_drop"}, {31'b0, done}, 32'd0);
        chk({tag, "_idle_result"}, result, exp);
    endtask

    initial begin
        #12;
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run("cmp_abcd_acca", 3'd0, 32'h61626364, 32'h61636361, 3'd0, 32'd0);
        run("cmp_ab_ab",     3'd0, 32'h00006162, 32'h00006162, 3'd0, 32'd1);
        run("cmp_ab_ac",     3'd0, 32'h00006162, 32'h00006163, 3'd0, 32'd0);
        run("cmp_window",    3'd0, 32'h11006162, 32'h22006162, 3'd2, 32'd1);
        run("cmp_len7",      3'd0, 32'h11006162, 32'h22006162, 3'd7, 32'd0);
        run("up_AbCd",       3'd1, 32'h41624364, 32'h0, 3'd0, 32'h41424344);
        run("up_ab",         3'd1, 32'h00006162, 32'h0, 3'd0, 32'h00004142);
        run("up_bounds",     3'd1, 32'h607B7A61, 32'h0, 3'd0, 32'h607B5A41);
        run("up_len2",       3'd1, 32'h61626364, 32'h0, 3'd2, 32'h61624344);
        run("up_len5",       3'd1, 32'h61626364, 32'h0, 3'd5, 32'h41424344);
        run("lo_ABCD",       3'd2, 32'h41424344, 32'h0, 3'd0, 32'h61626364);
        run("lo_Ab",         3'd2, 32'h00004162, 32'h0, 3'd0, 32'h00006162);
        run("lo_a1bZ",       3'd2, 32'h61315B5A, 32'h0, 3'd0, 32'h61315B7A);
        run("lo_bounds",     3'd2, 32'h405B5A41, 32'h0, 3'd0, 32'h405B7A61);
        run("unsup_5",       3'd5, 32'h61626364, 32'h61626364, 3'd0, 32'd0);
`ifdef STRING_HW_STRLEN_EN
        run("strlen_ab",     3'd3, 32'h00006162, 32'h0, 3'd0, 32'd2);
        run("strlen_win",    3'd3, 32'h41420043, 32'h0, 3'd3, 32'd2);
`else
        run("strlen_off",    3'd3, 32'h00006162, 32'h0, 3'd0, 32'd0);
`endif
        run("pre_reset",     3'd1, 32'h61626364, 32'h0, 3'd0, 32'h41424344);
        @(negedge clk);
        index = 3'd2; A = 32'h41424344; B = 32'h0; length = 3'd0; go = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("midrun_reset_done", {31'b0, done}, 32'd0);
        chk("midrun_reset_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        wait_done("post_reset");
        chk("post_reset_result", result, 32'h61626364);
        @(negedge clk);
        go = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_drop", {31'b0, done}, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
